write_back: RTL and testbench
=============================

Name: write_back

Overview:
- Final pipeline stage, after execute.
- Takes the execute result and retires it: ALU/LOADC results go straight into the register set; LOAD/STORE accesses go out to data memory through a ready handshake.
- Freezes upstream stages while a memory access is outstanding.
- Mirrors every register-set write onto a forwarding port for the data-forwarding unit.

Parameters:
- D_SIZE, 32, data/register width.
- A_SIZE, 10, data-memory address width.
- MAX_WAIT, 15, maximum cycles waiting for mem_ready before abort (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- reg_we_en_ex  in  1  instruction in execute writes a register.
- mem_re_ex  in  1  instruction in execute is LOAD.
- mem_we_ex  in  1  instruction in execute is STORE.
- dest_reg_ex  in  3  destination register.
- result_ex  in  D_SIZE  ALU/LOADC result, or memory address for LOAD/STORE.
- store_data_ex  in  D_SIZE  STORE data.
- mem_addr  out  A_SIZE  data-memory address.
- mem_wdata  out  D_SIZE  data-memory write data.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_rdata  in  D_SIZE  data-memory read data.
- mem_ready  in  1  memory completes the current access this cycle.
- rs_we  out  1  register-set write enable.
- rs_waddr  out  3  register-set write address.
- rs_wdata  out  D_SIZE  register-set write data.
- wb_valid  out  1  forwarding: write-back data valid (equals rs_we).
- wb_dest  out  3  forwarding: destination (equals rs_waddr).
- wb_data  out  D_SIZE  forwarding: data (equals rs_wdata).
- freeze  out  1  stall fetch/read/execute.
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset (async, immediate):
  - All outputs 0; FSM IDLE; wait counter 0; mem_err 0.
  - An in-flight access is dropped: strobes fall immediately and no register write is performed.
- FSM states: IDLE, MEM_RD, MEM_WR.
- freeze = (state != IDLE), combinational from the state register.
- Capture: inputs are sampled at a rising edge only when state is IDLE. While freeze=1, execute holds its outputs and this block ignores them.
- IDLE, reg_we_en_ex=1, no memory op: next edge drives rs_we=1, rs_waddr=dest_reg_ex, rs_wdata=result_ex for exactly one cycle. Latency 1. Back-to-back instructions give rs_we high on consecutive cycles.
- IDLE, mem_re_ex=1:
  - Next edge: mem_read=1, mem_addr=result_ex[A_SIZE-1:0]; latch dest_reg_ex; counter=0; go MEM_RD.
- IDLE, mem_we_ex=1 (and mem_re_ex=0):
  - Next edge: mem_write=1, mem_addr as above, mem_wdata=store_data_ex; go MEM_WR.
  - No register write, regardless of reg_we_en_ex.
- mem_re_ex and mem_we_ex both 1: treated as LOAD; mem_err set.
- MEM_RD/MEM_WR, at each edge:
  - mem_ready=1: strobe falls, state returns to IDLE, freeze falls.
  - In MEM_RD, that same edge also drives rs_we=1, rs_waddr=latched dest, rs_wdata=mem_rdata for one cycle.
  - Access latency = 1 + number of wait cycles.
  - mem_ready=0 and counter == MAX_WAIT-1: abort. Strobe falls; IDLE; mem_err=1 (sticky until rst); no register write.
  - Otherwise: counter increments; strobe, address and data are held stable.
- mem_ready while IDLE is ignored.
- Upper bits of result_ex beyond A_SIZE are ignored for addressing.
- Register 0 is an ordinary register (no hardwiring).
- Counter width: clog2(MAX_WAIT+1) bits; it never wraps, because abort precedes wrap.
- The instruction presented in the same cycle the FSM returns to IDLE is captured at the next edge. No instruction is lost or duplicated.

Decomposition:
- Shared include, alongside opcode.v: FSM state encodings WB_IDLE, WB_MEM_RD, WB_MEM_WR, and default D_SIZE/A_SIZE values.
- One sub-module is natural: wb_mem_fsm, containing the memory handshake FSM, wait counter and abort logic.
- Top level holds the result pipeline register and the register-set/forwarding output mux.

Test Plan:
- Reset then ALU write: reg_we_en_ex=1, dest=3, result=0x0000_00AA for one cycle -> next cycle rs_we=1, rs_waddr=3, rs_wdata=0xAA, wb_* identical; rs_we=0 the following cycle; freeze never asserted.
- LOAD with 2 wait cycles: mem_re_ex=1, dest=5, result=0x0000_0404 -> mem_read=1 and mem_addr=0x004 for 3 cycles, freeze=1 throughout; mem_ready=1, mem_rdata=0xDEAD_BEEF on the third -> rs_we=1, rs_waddr=5, rs_wdata=0xDEADBEEF; freeze=0.
- STORE zero-wait: mem_we_ex=1, result=0x3FF, store_data=0x1234, reg_we_en_ex=1, mem_ready tied 1 -> mem_write=1 for exactly 1 cycle, mem_wdata=0x1234; rs_we stays 0.
- Timeout: LOAD with mem_ready held 0 -> mem_read drops after exactly MAX_WAIT=15 cycles; mem_err=1 and remains 1; no rs_we pulse.
- Reset mid-access: assert rst during cycle 2 of MEM_RD -> mem_read, freeze and rs_we all 0 asynchronously; after release, an ALU write (dest=1, 0x55) completes normally.
- Back-to-back: LOAD (1 wait) followed by ALU instr held during freeze (dest=2, 0x77) -> load write, then ALU write on the next cycle; each rs_we pulse once.

Source files
------------

// File: rtl/write_back_pkg.sv
// Shared definitions for the write-back stage: default widths and the
// memory-handshake FSM state encoding.
package write_back_pkg;

    localparam int WB_D_SIZE   = 32;
    localparam int WB_A_SIZE   = 10;
    localparam int WB_MAX_WAIT = 15;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'b00,
        WB_MEM_RD = 2'b01,
        WB_MEM_WR = 2'b10
    } wb_state_t;

    // True when the executing instruction needs the data-memory port.
    function automatic logic wb_is_mem_op(input logic re, input logic we);
        return re | we;
    endfunction

endpackage

// File: rtl/wb_mem_fsm.sv
// Data-memory handshake for the write-back stage: issues LOAD/STORE
// strobes, waits for mem_ready, and aborts after MAX_WAIT cycles.
module wb_mem_fsm
    import write_back_pkg::*;
#(
    parameter int D_SIZE   = WB_D_SIZE,
    parameter int A_SIZE   = WB_A_SIZE,
    parameter int MAX_WAIT = WB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re_ex,
    input  logic              mem_we_ex,
    input  logic [2:0]        dest_reg_ex,
    input  logic [A_SIZE-1:0] addr_ex,
    input  logic [D_SIZE-1:0] store_data_ex,
    input  logic              mem_ready,
    output logic [A_SIZE-1:0] mem_addr,
    output logic [D_SIZE-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              freeze,
    output logic              mem_err,
    output logic              ld_done,
    output logic [2:0]        ld_dest
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    wb_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       ld_dest_r;

    assign freeze  = (state_r != WB_IDLE);
    assign ld_done = (state_r == WB_MEM_RD) && mem_ready;
    assign ld_dest = ld_dest_r;

    // Handshake FSM: capture accesses in IDLE, complete or abort while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= WB_IDLE;
            cnt_r     <= '0;
            ld_dest_r <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            case (state_r)
                WB_IDLE: begin
                    cnt_r <= '0;
                    if (mem_re_ex) begin
                        // A simultaneous STORE request is malformed; run it as LOAD and flag it.
                        state_r   <= WB_MEM_RD;
                        mem_read  <= 1'b1;
                        mem_addr  <= addr_ex;
                        ld_dest_r <= dest_reg_ex;
                        if (mem_we_ex) begin
                            mem_err <= 1'b1;
                        end else begin
                            mem_err <= mem_err;
                        end
                    end else if (mem_we_ex) begin
                        state_r   <= WB_MEM_WR;
                        mem_write <= 1'b1;
                        mem_addr  <= addr_ex;
                        mem_wdata <= store_data_ex;
                    end else begin
                        state_r <= WB_IDLE;
                    end
                end
                WB_MEM_RD, WB_MEM_WR: begin
                    if (mem_ready) begin
                        state_r   <= WB_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cnt_r     <= '0;
                    end else if (cnt_r == LAST_CNT) begin
                        // Timeout: drop the access without a register write.
                        state_r   <= WB_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        cnt_r     <= '0;
                        mem_err   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= WB_IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    cnt_r     <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/write_back.sv
// Write-back stage: retires ALU/LOADC results into the register set,
// drives data memory for LOAD/STORE, and mirrors writes to forwarding.
module write_back
    import write_back_pkg::*;
#(
    parameter int D_SIZE   = WB_D_SIZE,
    parameter int A_SIZE   = WB_A_SIZE,
    parameter int MAX_WAIT = WB_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we_en_ex,
    input  logic              mem_re_ex,
    input  logic              mem_we_ex,
    input  logic [2:0]        dest_reg_ex,
    input  logic [D_SIZE-1:0] result_ex,
    input  logic [D_SIZE-1:0] store_data_ex,
    output logic [A_SIZE-1:0] mem_addr,
    output logic [D_SIZE-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [D_SIZE-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              rs_we,
    output logic [2:0]        rs_waddr,
    output logic [D_SIZE-1:0] rs_wdata,
    output logic              wb_valid,
    output logic [2:0]        wb_dest,
    output logic [D_SIZE-1:0] wb_data,
    output logic              freeze,
    output logic              mem_err
);

    logic       ld_done_s;
    logic [2:0] ld_dest_s;
    logic       alu_wr_s;

    wb_mem_fsm #(
        .D_SIZE   (D_SIZE),
        .A_SIZE   (A_SIZE),
        .MAX_WAIT (MAX_WAIT)
    ) u_mem_fsm (
        .clk           (clk),
        .rst           (rst),
        .mem_re_ex     (mem_re_ex),
        .mem_we_ex     (mem_we_ex),
        .dest_reg_ex   (dest_reg_ex),
        .addr_ex       (result_ex[A_SIZE-1:0]),
        .store_data_ex (store_data_ex),
        .mem_ready     (mem_ready),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .freeze        (freeze),
        .mem_err       (mem_err),
        .ld_done       (ld_done_s),
        .ld_dest       (ld_dest_s)
    );

    // Direct register write only from IDLE and only for non-memory instructions.
    assign alu_wr_s = !freeze && reg_we_en_ex && !wb_is_mem_op(mem_re_ex, mem_we_ex);

    // Result pipeline register feeding the register set; a completing load has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_we    <= 1'b0;
            rs_waddr <= 3'd0;
            rs_wdata <= '0;
        end else if (ld_done_s) begin
            rs_we    <= 1'b1;
            rs_waddr <= ld_dest_s;
            rs_wdata <= mem_rdata;
        end else if (alu_wr_s) begin
            rs_we    <= 1'b1;
            rs_waddr <= dest_reg_ex;
            rs_wdata <= result_ex;
        end else begin
            rs_we <= 1'b0;
        end
    end

    assign wb_valid = rs_we;
    assign wb_dest  = rs_waddr;
    assign wb_data  = rs_wdata;

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: builds a per-cycle expected timeline
// from a list of instructions and random memory latencies, then replays it.
module tb_write_back;

    localparam int MW = 15;
    localparam int SZ = 4096;
    localparam int K_NOP = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3, K_BOTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_we_en_ex, mem_re_ex, mem_we_ex;
    logic [2:0]  dest_reg_ex;
    logic [31:0] result_ex, store_data_ex;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        rs_we;
    logic [2:0]  rs_waddr;
    logic [31:0] rs_wdata;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [31:0] wb_data;
    logic        freeze, mem_err;

    // Free-running clock.
    always #5 clk = ~clk;

    write_back dut (
        .clk(clk), .rst(rst),
        .reg_we_en_ex(reg_we_en_ex), .mem_re_ex(mem_re_ex), .mem_we_ex(mem_we_ex),
        .dest_reg_ex(dest_reg_ex), .result_ex(result_ex), .store_data_ex(store_data_ex),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rs_we(rs_we), .rs_waddr(rs_waddr), .rs_wdata(rs_wdata),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .freeze(freeze), .mem_err(mem_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cur_n   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", tag, cur_n, obs, exp);
        end
    endtask

    typedef struct {
        int          kind;
        logic [2:0]  dest;
        logic [31:0] res;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          w;
        logic        rwe;
    } instr_t;

    instr_t prog[$];

    // stimulus per edge n
    logic        i_re[SZ], i_we[SZ], i_rwe[SZ], i_rdy[SZ];
    logic [2:0]  i_dest[SZ];
    logic [31:0] i_res[SZ], i_sd[SZ], i_rd[SZ];
    // expected outputs after edge n
    logic        x_rswe[SZ], x_rd[SZ], x_wr[SZ], x_frz[SZ];
    logic [2:0]  x_dest[SZ];
    logic [31:0] x_data[SZ], x_wdata[SZ];
    logic [9:0]  x_addr[SZ];
    int          err_from;
    int          last_n;

    function automatic instr_t mk(input int kind, input logic [2:0] dest, input logic [31:0] res,
                                  input logic [31:0] sdata, input logic [31:0] rdata,
                                  input int w, input logic rwe);
        instr_t r;
        r.kind = kind; r.dest = dest; r.res = res; r.sdata = sdata;
        r.rdata = rdata; r.w = w; r.rwe = rwe;
        return r;
    endfunction

    function automatic instr_t rand_instr(input int max_w);
        instr_t r;
        r.kind  = int'($urandom_range(0, 3));
        r.dest  = 3'($urandom_range(0, 7));
        r.res   = $urandom;
        r.sdata = $urandom;
        r.rdata = $urandom;
        r.w     = int'($urandom_range(0, max_w));
        r.rwe   = (r.kind == K_NOP) ? 1'b0 :
                  (r.kind == K_STORE) ? 1'($urandom_range(0, 1)) : 1'b1;
        return r;
    endfunction

    // Expand the instruction list into a per-cycle timeline of inputs and expected outputs.
    task automatic build();
        int t, pstart, nxt, n_acc;
        logic is_ld;
        for (int e = 0; e < SZ; e++) begin
            i_re[e] = 1'b0; i_we[e] = 1'b0; i_rwe[e] = 1'b0; i_dest[e] = 3'd0;
            i_res[e] = 32'd0; i_sd[e] = 32'd0;
            i_rdy[e] = 1'($urandom_range(0, 1));
            i_rd[e]  = $urandom;
            x_rswe[e] = 1'b0; x_rd[e] = 1'b0; x_wr[e] = 1'b0; x_frz[e] = 1'b0;
            x_dest[e] = 3'd0; x_data[e] = 32'd0; x_wdata[e] = 32'd0; x_addr[e] = 10'd0;
        end
        err_from = SZ + 1;
        t = 1;
        pstart = 1;
        foreach (prog[i]) begin
            // the instruction is presented from the cycle after the previous capture until its own capture
            for (int e = pstart; e <= t; e++) begin
                i_re[e]   = (prog[i].kind == K_LOAD) || (prog[i].kind == K_BOTH);
                i_we[e]   = (prog[i].kind == K_STORE) || (prog[i].kind == K_BOTH);
                i_rwe[e]  = prog[i].rwe;
                i_dest[e] = prog[i].dest;
                i_res[e]  = prog[i].res;
                i_sd[e]   = prog[i].sdata;
            end
            if (prog[i].kind == K_ALU || prog[i].kind == K_NOP) begin
                if (prog[i].rwe) begin
                    x_rswe[t] = 1'b1; x_dest[t] = prog[i].dest; x_data[t] = prog[i].res;
                end
                nxt = t + 1;
            end else begin
                is_ld = (prog[i].kind != K_STORE);
                n_acc = (prog[i].w + 1 < MW) ? prog[i].w + 1 : MW;
                for (int k = 0; k < n_acc; k++) begin
                    x_rd[t+k]    = is_ld;
                    x_wr[t+k]    = !is_ld;
                    x_addr[t+k]  = prog[i].res[9:0];
                    x_wdata[t+k] = prog[i].sdata;
                    x_frz[t+k]   = 1'b1;
                end
                for (int e = t + 1; e <= t + n_acc; e++) i_rdy[e] = 1'b0;
                if (prog[i].w < MW) begin
                    i_rdy[t+n_acc] = 1'b1;
                    i_rd[t+n_acc]  = prog[i].rdata;
                    if (is_ld) begin
                        x_rswe[t+n_acc] = 1'b1;
                        x_dest[t+n_acc] = prog[i].dest;
                        x_data[t+n_acc] = prog[i].rdata;
                    end
                end else if (t + n_acc < err_from) begin
                    err_from = t + n_acc;
                end
                if (prog[i].kind == K_BOTH && t < err_from) err_from = t;
                nxt = t + n_acc + 1;
            end
            pstart = t + 1;
            t = nxt;
        end
        last_n = t;
    endtask

    // Replay the timeline: drive at negedge, check outputs at the following negedge.
    task automatic run();
        for (int n = 1; n <= last_n; n++) begin
            reg_we_en_ex  = i_rwe[n];
            mem_re_ex     = i_re[n];
            mem_we_ex     = i_we[n];
            dest_reg_ex   = i_dest[n];
            result_ex     = i_res[n];
            store_data_ex = i_sd[n];
            mem_ready     = i_rdy[n];
            mem_rdata     = i_rd[n];
            @(posedge clk);
            @(negedge clk);
            cur_n = n;
            check_val("rs_we", 32'(rs_we), 32'(x_rswe[n]));
            check_val("wb_valid", 32'(wb_valid), 32'(x_rswe[n]));
            if (x_rswe[n]) begin
                check_val("rs_waddr", 32'(rs_waddr), 32'(x_dest[n]));
                check_val("rs_wdata", rs_wdata, x_data[n]);
                check_val("wb_dest", 32'(wb_dest), 32'(x_dest[n]));
                check_val("wb_data", wb_data, x_data[n]);
            end
            check_val("mem_read", 32'(mem_read), 32'(x_rd[n]));
            check_val("mem_write", 32'(mem_write), 32'(x_wr[n]));
            check_val("freeze", 32'(freeze), 32'(x_frz[n]));
            check_val("mem_err", 32'(mem_err), 32'(n >= err_from));
            if (x_rd[n] || x_wr[n]) check_val("mem_addr", 32'(mem_addr), 32'(x_addr[n]));
            if (x_wr[n]) check_val("mem_wdata", mem_wdata, x_wdata[n]);
        end
    endtask

    task automatic idle_inputs();
        reg_we_en_ex = 1'b0; mem_re_ex = 1'b0; mem_we_ex = 1'b0;
        dest_reg_ex = 3'd0; result_ex = 32'd0; store_data_ex = 32'd0;
        mem_ready = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        cur_n = 0;
        check_val("rst rs_we", 32'(rs_we), 32'd0);
        check_val("rst rs_wdata", rs_wdata, 32'd0);
        check_val("rst wb_valid", 32'(wb_valid), 32'd0);
        check_val("rst mem_read", 32'(mem_read), 32'd0);
        check_val("rst mem_write", 32'(mem_write), 32'd0);
        check_val("rst mem_addr", 32'(mem_addr), 32'd0);
        check_val("rst freeze", 32'(freeze), 32'd0);
        check_val("rst mem_err", 32'(mem_err), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        do_reset();

        // Phase 1: directed scenarios plus random traffic without timeouts, then one timeout.
        prog.delete();
        prog.push_back(mk(K_ALU,   3'd3, 32'h0000_00AA, 32'd0,      32'd0,        0, 1'b1));
        prog.push_back(mk(K_LOAD,  3'd5, 32'h0000_0404, 32'd0,      32'hDEAD_BEEF, 2, 1'b1));
        prog.push_back(mk(K_STORE, 3'd6, 32'h0000_03FF, 32'h1234,   32'd0,        0, 1'b1));
        prog.push_back(mk(K_LOAD,  3'd4, 32'hFFFF_F123, 32'd0,      32'h0BAD_F00D, 1, 1'b1));
        prog.push_back(mk(K_ALU,   3'd2, 32'h0000_0077, 32'd0,      32'd0,        0, 1'b1));
        prog.push_back(mk(K_ALU,   3'd0, 32'hCAFE_0000, 32'd0,      32'd0,        0, 1'b1));
        for (int i = 0; i < 60; i++) prog.push_back(rand_instr(4));
        prog.push_back(mk(K_LOAD,  3'd7, 32'h0000_0155, 32'd0,      32'h1111_2222, MW, 1'b1));
        prog.push_back(mk(K_ALU,   3'd1, 32'h0000_0099, 32'd0,      32'd0,        0, 1'b1));
        build();
        run();

        // Phase 2: malformed LOAD+STORE sets the error, then random traffic including timeouts.
        do_reset();
        prog.delete();
        prog.push_back(mk(K_BOTH,  3'd3, 32'h0000_0200, 32'h5555,   32'h7777_8888, 0, 1'b1));
        for (int i = 0; i < 40; i++) prog.push_back(rand_instr(MW + 1));
        build();
        run();

        // Phase 3: reset in the middle of a load drops it immediately.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_re_ex = 1'b1; reg_we_en_ex = 1'b1; dest_reg_ex = 3'd5;
        result_ex = 32'h0000_0010; mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cur_n = 1;
        check_val("mid mem_read", 32'(mem_read), 32'd1);
        check_val("mid freeze", 32'(freeze), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cur_n = 2;
        check_val("async mem_read", 32'(mem_read), 32'd0);
        check_val("async freeze", 32'(freeze), 32'd0);
        check_val("async rs_we", 32'(rs_we), 32'd0);
        check_val("async mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        reg_we_en_ex = 1'b1; dest_reg_ex = 3'd1; result_ex = 32'h0000_0055;
        mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cur_n = 3;
        check_val("post rs_we", 32'(rs_we), 32'd1);
        check_val("post rs_waddr", 32'(rs_waddr), 32'd1);
        check_val("post rs_wdata", rs_wdata, 32'h0000_0055);
        check_val("post freeze", 32'(freeze), 32'd0);
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        cur_n = 4;
        check_val("post rs_we off", 32'(rs_we), 32'd0);
        check_val("post mem_read", 32'(mem_read), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
